uart_rx: RTL
============

# uart_rx

UART receiver for the SoC serial port: samples the asynchronous `rx` line (board FTDI TX pin), deframes 8N1 characters and presents received bytes to the bus-side consumer through a valid/ready handshake, buffered by a small FIFO. It is the receive-direction counterpart of the SoC UART transmitter that drives `tx`, and uses the same baud parameters.

## Interface
Parameters:
- `CLK_HZ`, default 25000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of two, ≥ 2.

Derived constants:
- `CPB = (CLK_HZ + BAUD/2) / BAUD`: integer clocks per bit, 217 at the defaults.
- `HALF = CPB / 2`: integer division.

Ports:
- `clock`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `rx`, input, 1: asynchronous serial line, idle high.
- `data`, output, 8: head-of-FIFO byte. Valid only while `valid` is high.
- `valid`, output, 1: FIFO non-empty.
- `ready`, input, 1: consumer pop. A byte transfers on a clock edge where `valid && ready`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit samples 0.
- `overrun`, output, 1: one-cycle pulse when a completed byte is dropped because the FIFO is full.

## Operation
**Input synchronizer**
- `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.

**State machine** (states IDLE, START, DATA, STOP, BREAK), with down-counter `cnt` and bit index `idx`:
- IDLE → START when `rx_s` = 0. Load `cnt` = HALF−1.
- In every state except IDLE and BREAK, `cnt` decrements each cycle. A sample is taken when `cnt` = 0, and `cnt` reloads to CPB−1.
- START sample:
  - `rx_s` = 1: false start; go to IDLE with no output.
  - `rx_s` = 0: go to DATA with `idx` = 0.
- DATA sample: shift `rx_s` into the shift register LSB-first and increment `idx`. After the sample with `idx` = 7, go to STOP.
- STOP sample:
  - `rx_s` = 1: push the byte, go to IDLE.
  - `rx_s` = 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK → IDLE on the first cycle `rx_s` = 1. This prevents a held-low line from re-triggering repeatedly.

**FIFO**
- Implemented with read/write pointers one bit wider than log2(FIFO_DEPTH). Pointers wrap modulo 2·FIFO_DEPTH.
  - Empty: pointers equal.
  - Full: pointers differ only in the MSB.
- Push while full and no pop in the same cycle: byte dropped, `overrun` pulses, FIFO contents unchanged.
- Push and pop in the same cycle: both take effect, including when the FIFO is full. No overrun occurs and the occupancy is unchanged.
- Pop while empty: ignored.

**Reset**
- Reset mid-character returns the FSM to IDLE and empties the FIFO. The partial byte is lost.
- Reset values: `valid` = 0, `frame_err` = 0, `overrun` = 0, `data` = 0, `cnt` = 0, `idx` = 0, state = IDLE.

## Timing
- Pin-to-`rx_s` latency: 2 cycles.
- Let cycle 0 be the first cycle IDLE sees `rx_s` = 0. Then:
  - start sample at cycle HALF;
  - data bit i sampled at HALF + (i+1)·CPB;
  - stop bit sampled at HALF + 9·CPB;
  - `valid` (or `frame_err` / `overrun`) asserted at HALF + 9·CPB + 1.
- After a good stop, IDLE is re-entered at HALF + 9·CPB + 1. A start bit beginning exactly at the nominal end of the stop bit is accepted, so back-to-back characters are received with no gap.
- `data` and `valid` are registered FIFO outputs. After a pop, the next entry appears on the following cycle.
- Tolerated baud mismatch: about ±4%, set by the mid-bit sampling.

## Configuration
- `UART_RX_FIFO_EN`:
  - **Defined:** FIFO of `FIFO_DEPTH` entries as described above.
  - **Undefined:** single holding register (depth 1). `FIFO_DEPTH` is ignored.
    - `valid` sets on push and clears on pop.
    - Push while `valid` and no pop: `overrun` pulses and the held byte is kept.
    - Push and pop in the same cycle: the new byte replaces the held one and `valid` stays 1.

## Test plan
Benches use `CLK_HZ` = 1600000, `BAUD` = 100000 (CPB = 16, HALF = 8), `FIFO_DEPTH` = 4.
1. **Single byte:** drive 0xA5 8N1 with `ready` = 1 → `valid` high for exactly 1 cycle, HALF + 9·CPB + 1 = 153 cycles after `rx_s` falls, with `data` = 0xA5.
2. **False start:** 5-cycle low glitch on `rx` → no `valid`, no `frame_err`. FSM back in IDLE and receives a following 0x3C correctly.
3. **Framing error:** 0x55 with stop bit 0, line held low 40 cycles then high → exactly one `frame_err` pulse and no push. The next byte 0x0F is received.
4. **Full FIFO:** `ready` = 0, send 0x01..0x05 back-to-back → `overrun` pulses once, at the 5th byte's stop. Popping then yields 0x01, 0x02, 0x03, 0x04 and `valid` = 0.
5. **Full, simultaneous push/pop:** FIFO full, `ready` asserted on the 5th byte's push cycle → no `overrun`. Pop order is 0x01..0x05.
6. **Reset mid-byte:** assert `reset` for 1 cycle during DATA bit 3 → outputs are 0 the next cycle, no byte is produced, and a subsequent 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
// The master presents data/valid, and the slave answers with ready.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a 1-entry holding register.
module uart_rx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     rx,
  uart_rx_if.master bus,
  output logic     frame_err,
  output logic     overrun
);

  localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_m, rx_s;
  logic          tick;
  logic          push;
  logic          ferr_d;
  logic          pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      frame_err <= ferr_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      START, DATA, STOP: begin
        cnt_d = tick ? CW'(CPB - 1) : cnt_q - CW'(1);
        if (tick) begin
          unique case (1'b1)
            state_q == START: begin
              state_d = rx_s ? IDLE : DATA;
              idx_d   = '0;
            end
            state_q == DATA: begin
              shreg_d = {rx_s, shreg_q[7:1]};
              idx_d   = idx_q + 3'd1;
              if (idx_q == 3'd7) state_d = STOP;
            end
            default: begin
              // a low stop bit means the line may be held in break
              push    = rx_s;
              ferr_d  = !rx_s;
              state_d = rx_s ? IDLE : BREAK;
            end
          endcase
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full;

  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign pop   = !empty && bus.ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      // a pop frees the slot the push lands in, so full+pop still accepts
      if (push && (!full || pop)) begin
        mem[wptr[AW-1:0]] <= shreg_q;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      overrun <= push && full && !pop;
    end
  end

  assign bus.valid = !empty;
  assign bus.data  = mem[rptr[AW-1:0]];
`else
  logic [7:0] hold_q;
  logic       held_q;
  logic       unused_depth;

  // depth is fixed at one entry in this build
  assign unused_depth = FIFO_DEPTH[0];
  assign pop          = held_q && bus.ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q  <= '0;
      held_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push && (!held_q || pop)) begin
        hold_q <= shreg_q;
        held_q <= 1'b1;
      end else if (pop) begin
        held_q <= 1'b0;
      end
      overrun <= push && held_q && !pop;
    end
  end

  assign bus.valid = held_q;
  assign bus.data  = hold_q;
`endif

endmodule
